// File: rtl/regfile_mp_scoreboard.sv
// regfile_mp_scoreboard
//   Multi-port register file with a per-register busy scoreboard.
//   - Two combinational read ports.
//   - Two clocked write ports: A is ALU writeback and B is load writeback.
//     When both ports write the same address, port B wins.
//   - Register 0 always reads as zero and is never busy.
//   - Decode marks a destination busy with Issue_En/Issue_Adr.
//     Writeback to that register clears the busy bit.
//
//   Ports
//     Clock, Reset              rising-edge clock, async active-high reset
//     WEn_A/Write_Adr_A/Data_A  write port A
//     WEn_B/Write_Adr_B/Data_B  write port B
//     Read_Adr_1/2              read addresses
//     Issue_En/Issue_Adr        marks a destination register busy
//     Read_Data_1/2             register contents
//     Busy_1/2                  busy bits of the read addresses
//     Write_Conflict            A and B write the same nonzero address
//
//   Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
//   data to the read ports. It also hides the busy bit of a register that is
//   being written, unless that register is re-issued in the same cycle.
module regfile_mp_scoreboard #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADR_W  = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WEn_A,
  input  logic [ADR_W-1:0]  Write_Adr_A,
  input  logic [DATA_W-1:0] Write_Data_A,
  input  logic              WEn_B,
  input  logic [ADR_W-1:0]  Write_Adr_B,
  input  logic [DATA_W-1:0] Write_Data_B,
  input  logic [ADR_W-1:0]  Read_Adr_1,
  input  logic [ADR_W-1:0]  Read_Adr_2,
  input  logic              Issue_En,
  input  logic [ADR_W-1:0]  Issue_Adr,
  output logic [DATA_W-1:0] Read_Data_1,
  output logic [DATA_W-1:0] Read_Data_2,
  output logic              Busy_1,
  output logic              Busy_2,
  output logic              Write_Conflict
);

  localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [DEPTH-1:0]  set_mask;
  logic [DEPTH-1:0]  clr_mask;
  logic              wr_a;
  logic              wr_b;
  logic              iss;

  // Writes and issues that target register 0 are ignored.
  // Removing them here keeps every later use simple.
  assign wr_a = WEn_A && (Write_Adr_A != '0);
  assign wr_b = WEn_B && (Write_Adr_B != '0);
  assign iss  = Issue_En && (Issue_Adr != '0);

  assign Write_Conflict = wr_a && wr_b && (Write_Adr_A == Write_Adr_B);

  // Compute the next scoreboard value.
  // Writebacks clear their register's busy bit. A same-edge issue then sets
  // it again, because the newly issued producer is still outstanding.
  // Bit 0 is forced low so register 0 is never busy.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss)
      set_mask = ONE_HOT0 << Issue_Adr;
    if (wr_a)
      clr_mask = clr_mask | (ONE_HOT0 << Write_Adr_A);
    if (wr_b)
      clr_mask = clr_mask | (ONE_HOT0 << Write_Adr_B);
    busy_next = ((busy & ~clr_mask) | set_mask) & ~ONE_HOT0;
  end

  // Register storage.
  // Port B is written after port A, so B's data is kept on a same-address
  // collision. Reset clears everything immediately, including a write that
  // is in flight.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (wr_a)
        regs[Write_Adr_A] <= Write_Data_A;
      if (wr_b)
        regs[Write_Adr_B] <= Write_Data_B;
    end
  end

  // Scoreboard state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      busy <= '0;
    else
      busy <= busy_next;
  end

  // Read data path, shared by both read ports.
  // With bypass, a matching write this cycle supplies the data, and port B
  // is checked last so it takes priority. Bypass is disabled during reset so
  // the outputs read zero.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADR_W-1:0] adr);
    logic [DATA_W-1:0] val;
    val = regs[adr];
`ifdef REGFILE_BYPASS_EN
    if (!Reset) begin
      if (wr_a && (Write_Adr_A == adr))
        val = Write_Data_A;
      if (wr_b && (Write_Adr_B == adr))
        val = Write_Data_B;
    end
`endif
    if (adr == '0)
      val = '0;
    return val;
  endfunction

  // Busy lookup, shared by both read ports.
  // With bypass, a register whose data is being forwarded is reported not
  // busy, unless decode is issuing to that register again in this cycle.
  function automatic logic busy_port(input logic [ADR_W-1:0] adr);
    logic bsy;
    bsy = busy[adr];
`ifdef REGFILE_BYPASS_EN
    if (!Reset && ((wr_a && (Write_Adr_A == adr)) || (wr_b && (Write_Adr_B == adr)))
        && !(iss && (Issue_Adr == adr)))
      bsy = 1'b0;
`endif
    if (adr == '0)
      bsy = 1'b0;
    return bsy;
  endfunction

  // The read ports are purely combinational from the current state.
  always_comb begin
    Read_Data_1 = read_port(Read_Adr_1);
    Read_Data_2 = read_port(Read_Adr_2);
    Busy_1      = busy_port(Read_Adr_1);
    Busy_2      = busy_port(Read_Adr_2);
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// tb_regfile_mp_scoreboard
//   Drives the register file with directed scenarios and then random
//   traffic. Outputs are compared against a behavioural model made of plain
//   arrays, which is updated from the architectural rules at every edge.
module tb_regfile_mp_scoreboard;

  logic        Clock;
  logic        Reset;
  logic        WEn_A;
  logic [4:0]  Write_Adr_A;
  logic [31:0] Write_Data_A;
  logic        WEn_B;
  logic [4:0]  Write_Adr_B;
  logic [31:0] Write_Data_B;
  logic [4:0]  Read_Adr_1;
  logic [4:0]  Read_Adr_2;
  logic        Issue_En;
  logic [4:0]  Issue_Adr;
  logic [31:0] Read_Data_1;
  logic [31:0] Read_Data_2;
  logic        Busy_1;
  logic        Busy_2;
  logic        Write_Conflict;

  logic [31:0] model_regs [32];
  logic        model_busy [32];

  int checks   = 0;
  int failures = 0;

  regfile_mp_scoreboard #(.DATA_W(32), .DEPTH(32), .ADR_W(5)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .WEn_A          (WEn_A),
    .Write_Adr_A    (Write_Adr_A),
    .Write_Data_A   (Write_Data_A),
    .WEn_B          (WEn_B),
    .Write_Adr_B    (Write_Adr_B),
    .Write_Data_B   (Write_Data_B),
    .Read_Adr_1     (Read_Adr_1),
    .Read_Adr_2     (Read_Adr_2),
    .Issue_En       (Issue_En),
    .Issue_Adr      (Issue_Adr),
    .Read_Data_1    (Read_Data_1),
    .Read_Data_2    (Read_Data_2),
    .Busy_1         (Busy_1),
    .Busy_2         (Busy_2),
    .Write_Conflict (Write_Conflict)
  );

  // Free-running 10-unit clock.
  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Compare one observed value with its expected value and report any miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Set every DUT input for the next cycle.
  task automatic applyStimulus(input logic wa, input logic [4:0] aa, input logic [31:0] da,
                               input logic wb, input logic [4:0] ab, input logic [31:0] db,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic ie, input logic [4:0] ia);
    WEn_A = wa; Write_Adr_A = aa; Write_Data_A = da;
    WEn_B = wb; Write_Adr_B = ab; Write_Data_B = db;
    Read_Adr_1 = r1; Read_Adr_2 = r2;
    Issue_En = ie; Issue_Adr = ia;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      model_regs[i] = '0;
      model_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] expRead(input logic [4:0] adr);
    if (adr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (WEn_B && Write_Adr_B == adr) return Write_Data_B;
    if (WEn_A && Write_Adr_A == adr) return Write_Data_A;
`endif
    return model_regs[adr];
  endfunction

  function automatic logic expBusy(input logic [4:0] adr);
    if (adr == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (((WEn_A && Write_Adr_A == adr) || (WEn_B && Write_Adr_B == adr))
        && !(Issue_En && Issue_Adr == adr))
      return 1'b0;
`endif
    return model_busy[adr];
  endfunction

  // Apply the architectural effect of one rising edge to the model.
  task automatic modelEdge();
    for (int r = 1; r < 32; r++) begin
      if (WEn_A && Write_Adr_A == r[4:0]) model_regs[r] = Write_Data_A;
      if (WEn_B && Write_Adr_B == r[4:0]) model_regs[r] = Write_Data_B;
      if (Issue_En && Issue_Adr == r[4:0])
        model_busy[r] = 1'b1;
      else if ((WEn_A && Write_Adr_A == r[4:0]) || (WEn_B && Write_Adr_B == r[4:0]))
        model_busy[r] = 1'b0;
    end
  endtask

  // Check all outputs mid-cycle, then advance one edge.
  // Inputs are expected to have been set just after the previous edge.
  task automatic runCycle();
    @(negedge Clock);
    checkOutput("read_data_1", Read_Data_1, expRead(Read_Adr_1));
    checkOutput("read_data_2", Read_Data_2, expRead(Read_Adr_2));
    checkOutput("busy_1", {31'b0, Busy_1}, {31'b0, expBusy(Read_Adr_1)});
    checkOutput("busy_2", {31'b0, Busy_2}, {31'b0, expBusy(Read_Adr_2)});
    checkOutput("write_conflict", {31'b0, Write_Conflict},
                {31'b0, WEn_A && WEn_B && Write_Adr_A == Write_Adr_B && Write_Adr_A != 0});
    @(posedge Clock);
    modelEdge();
    #1;
  endtask

  logic [4:0] rnd_adr [5];

  initial begin
    $display("[TB] start");
    Reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    modelReset();
    @(posedge Clock);
    #1;
    checkOutput("reset_read_1", Read_Data_1, 32'd0);
    checkOutput("reset_busy_1", {31'b0, Busy_1}, 32'd0);
    Reset = 1'b0;
    runCycle();

    // Basic write on port A, followed by a write with the enable low.
    applyStimulus(1, 1, 32, 0, 0, 0, 1, 2, 0, 0);
    runCycle();
    applyStimulus(0, 2, 64, 0, 0, 0, 1, 2, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    runCycle();

    // Read an address while it is being written, then read it again.
    applyStimulus(1, 3, 128, 0, 0, 0, 3, 1, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
    runCycle();

    // Same-address conflict, then an attempted write to register 0.
    applyStimulus(1, 5, 7, 1, 5, 9, 5, 0, 0, 0);
    runCycle();
    applyStimulus(1, 0, 32'hFFFF, 1, 0, 32'hFFFF, 5, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    runCycle();

    // Scoreboard: issue, then write plus re-issue, then write alone.
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0, 1, 4);
    runCycle();
    applyStimulus(0, 0, 0, 1, 4, 11, 4, 0, 1, 4);
    runCycle();
    applyStimulus(0, 0, 0, 1, 4, 12, 4, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0, 1, 0);
    runCycle();

    // Mid-cycle reset while a write and an issue to register 6 are pending.
    applyStimulus(1, 6, 55, 0, 0, 0, 6, 0, 1, 6);
    runCycle();
    applyStimulus(1, 6, 77, 0, 0, 0, 6, 6, 1, 6);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("midreset_read", Read_Data_1, 32'd0);
    checkOutput("midreset_busy", {31'b0, Busy_1}, 32'd0);
    modelReset();
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 3, 0, 0);
    runCycle();

    // Random traffic, concentrated on a few addresses to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 5; k++)
        rnd_adr[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
      applyStimulus(1'($urandom), rnd_adr[0], $urandom,
                    1'($urandom), rnd_adr[1], $urandom,
                    rnd_adr[2], rnd_adr[3],
                    1'($urandom), rnd_adr[4]);
      runCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
